// File: rtl/muldiv_seq_ctrl_if.sv
// muldiv_seq_ctrl_if: EX-stage issue/stall handshake and HI/LO result bus for the mult/div sequencer.
interface muldiv_seq_ctrl_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            hilo_read;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    modport master (output start, op, a, b, flush, hilo_read, input busy, stall, done, hi, lo);
    modport slave (input start, op, a, b, flush, hilo_read, output busy, stall, done, hi, lo);
endinterface

// File: rtl/muldiv_seq_ctrl.sv
// muldiv_seq_ctrl: iterative shift-add multiply / restoring divide writing HI/LO; define EARLY_TERM_EN to retire multiplies once the remaining multiplier bits are zero.
module muldiv_seq_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input logic              clk,
    input logic              rst_n,
    muldiv_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic              is_div, sgn_q, sgn_r;
    logic [2*XLEN-1:0] acc, opd, acc_nx, prod;
    logic [XLEN-1:0]   opm, abs_a, abs_b, quo, rem;
    logic [XLEN:0]     rem_sh, diff;
    logic              sa, sb, go, dz, last;
    assign go        = bus.start && !bus.flush && state == IDLE;
    assign dz        = bus.op[1] && bus.b == '0;
    assign sa        = !bus.op[0] && bus.a[XLEN-1];
    assign sb        = !bus.op[0] && bus.b[XLEN-1];
    assign abs_a     = sa ? -bus.a : bus.a;
    assign abs_b     = sb ? -bus.b : bus.b;
    assign bus.busy  = state != IDLE;
    assign bus.stall = bus.busy && (bus.start || bus.hilo_read);
    // Divide keeps remainder:quotient in acc; a clear diff MSB means the trial subtract fit.
    always_comb begin
        rem_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff   = rem_sh - {1'b0, opd[XLEN-1:0]};
        acc_nx = is_div ? (diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                      : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                        : acc + (opm[0] ? opd : '0);
`ifdef EARLY_TERM_EN
        last = cnt == CNT_W'(1) || (!is_div && opm[XLEN-1:1] == '0);
`else
        last = cnt == CNT_W'(1);
`endif
        prod     = sgn_q ? -acc : acc;
        quo      = sgn_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem      = sgn_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        state_nx = bus.flush ? IDLE :
                   state == IDLE ? (bus.start ? (dz ? FIX : CALC) : IDLE) :
                   state == CALC ? (last ? FIX : CALC) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    // Divide by zero preloads acc with {a, all-ones} and clears the signs so FIX passes it through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            sgn_q    <= 1'b0;
            sgn_r    <= 1'b0;
            acc      <= '0;
            opd      <= '0;
            opm      <= '0;
            bus.done <= 1'b0;
            bus.hi   <= '0;
            bus.lo   <= '0;
        end else begin
            bus.done <= 1'b0;
            if (bus.flush) cnt <= '0;
            else if (go) begin
                is_div <= bus.op[1];
                sgn_q  <= !dz && (sa ^ sb);
                sgn_r  <= !dz && sa;
                cnt    <= dz ? '0 : CNT_W'(XLEN);
                acc    <= dz ? {bus.a, {XLEN{1'b1}}} : bus.op[1] ? {{XLEN{1'b0}}, abs_a} : '0;
                opd    <= {{XLEN{1'b0}}, bus.op[1] ? abs_b : abs_a};
                opm    <= abs_b;
            end else if (state == CALC) begin
                acc <= acc_nx;
                opd <= is_div ? opd : opd << 1;
                opm <= opm >> 1;
                cnt <= last ? '0 : cnt - CNT_W'(1);
            end else if (state == FIX) begin
                bus.hi   <= is_div ? rem : prod[2*XLEN-1:XLEN];
                bus.lo   <= is_div ? quo : prod[XLEN-1:0];
                bus.done <= 1'b1;
            end
        end
    end
endmodule
